// File: rtl/dot_job_sequencer.sv
// dot_job_sequencer: feeds multi-chunk operand pairs into the dot-product core and sums the per-chunk results.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module dot_job_sequencer #(
  parameter int unsigned CORE_LAT = 2,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_a,
  input  logic [511:0]     in_b,
  output logic [511:0]     core_a,
  output logic [511:0]     core_b,
  input  logic [23:0]      core_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic [CORE_LAT:0]  tag_q, tag_d;
  logic [511:0]       core_a_q, core_a_d;
  logic [511:0]       core_b_q, core_b_d;

  logic               accept;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   core_ext;

  assign accept    = (state_q == S_RUN) && in_valid;
  assign cnt_inc   = cnt_q + 1'b1;
  assign core_ext  = {{(ACC_W-24){core_out[23]}}, core_out};

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_RUN);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    res_d    = res_q;
    core_a_d = '0;
    core_b_d = '0;
    // The tag pipe tracks which core results belong to accepted chunks.
    tag_d    = {tag_q[CORE_LAT-1:0], accept};

    if (tag_q[CORE_LAT]) begin
      acc_d = acc_q + core_ext;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          if (len != '0) begin
            len_d   = len;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          core_a_d = in_a;
          core_b_d = in_b;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tag_q[CORE_LAT] && (tag_q[CORE_LAT-1:0] == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      tag_d    = '0;
      acc_d    = '0;
      cnt_d    = '0;
      core_a_d = '0;
      core_b_d = '0;
    end

    // Snapshot the total on entry to DONE so it stays put after the handshake.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      res_d = acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      tag_q    <= '0;
      core_a_q <= '0;
      core_b_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_job_sequencer.sv
// tb_dot_job_sequencer: randomized and directed checks of dot_job_sequencer against a job-level reference model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_dot_job_sequencer;
  localparam int CORE_LAT = 2;
  localparam int LEN_W    = 8;
  localparam int ACC_W    = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, abort, in_valid, res_ready;
  logic [LEN_W-1:0]   len;
  logic [511:0]       in_a, in_b;
  logic               busy, in_ready, res_valid;
  logic [511:0]       core_a, core_b;
  logic [23:0]        core_out;
  logic [23:0]        core_s1;
  logic [ACC_W-1:0]   res_data;

  int checks = 0;
  int passes = 0;

  dot_job_sequencer #(.CORE_LAT(CORE_LAT), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_out(core_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dot(input logic [511:0] a, input logic [511:0] b);
    logic signed [23:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s += $signed(a[i*8 +: 8]) * $signed(b[i*8 +: 8]);
    return s;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Two-stage core stand-in sharing the sequencer's reset.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      core_s1  <= '0;
      core_out <= '0;
    end else begin
      core_s1  <= dot(core_a, core_b);
      core_out <= core_s1;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Job-level reference: a job is live from start until its result is taken or it is aborted.
  int               e = 0;
  bit               m_active = 0;
  int               m_left = 0;
  int               m_res_at = 0;
  logic [ACC_W-1:0] m_sum = '0;
  logic [ACC_W-1:0] m_res_data = '0;
  logic [511:0]     m_ca = '0, m_cb = '0;

  always @(posedge clk or posedge rst_n) begin
    logic [23:0] d;
    if (rst_n) begin
      m_active = 0; m_left = 0; m_res_at = 0; m_sum = '0; m_res_data = '0; m_ca = '0; m_cb = '0;
    end else begin
      e++;
      m_ca = '0; m_cb = '0;
      if (abort) begin
        m_active = 0; m_left = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_left = int'(len); m_sum = '0;
          if (len == 0) begin m_res_at = e; m_res_data = '0; end
        end
      end else if (m_left > 0) begin
        if (in_valid) begin
          d = dot(in_a, in_b);
          m_sum = m_sum + {{(ACC_W-24){d[23]}}, d};
          m_ca = in_a; m_cb = in_b;
          m_left--;
          if (m_left == 0) m_res_at = e + CORE_LAT + 1;
        end
      end else if (e == m_res_at) begin
        m_res_data = m_sum;
      end else if (e > m_res_at && res_ready) begin
        m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",      busy,      m_active);
    chk("in_ready",  in_ready,  m_active && m_left > 0);
    chk("res_valid", res_valid, m_active && m_left == 0 && e >= m_res_at);
    chk("res_data",  res_data,  m_res_data);
    chk("core_a",    core_a,    m_ca);
    chk("core_b",    core_b,    m_cb);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin step(); n++; end
    chk("wait res_valid", res_valid, 1'b1);
  endtask

  task automatic handshake();
    res_ready = 1; step(); res_ready = 0;
    chk("idle after handshake", busy, 1'b0);
  endtask

  task automatic start_job(input logic [LEN_W-1:0] l);
    start = 1; len = l; step(); start = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    logic [ACC_W-1:0] held;
    start = 0; abort = 0; in_valid = 0; res_ready = 0; len = '0; in_a = '0; in_b = '0;
    rst_n = 0; #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset res_data", res_data, 0);
    chk("reset core_a", core_a, 0);
    #1 rst_n = 0;
    step();

    // len=1, A=1, B=2 : result 128 three edges after acceptance
    start_job(8'd1);
    in_valid = 1; in_a = {64{8'h01}}; in_b = {64{8'h02}};
    step();
    in_valid = 0;
    chk("t1 in_ready after last", in_ready, 1'b0);
    chk("t1 busy", busy, 1'b1);
    step(); step();
    chk("t1 res_valid E0+2", res_valid, 1'b0);
    step();
    chk("t1 res_valid E0+3", res_valid, 1'b1);
    chk("t1 res_data", res_data, 128);
    handshake();
    chk("t1 res_valid low", res_valid, 1'b0);
    chk("t1 res_data kept", res_data, 128);

    // len=4 with gaps in in_valid
    start_job(8'd4);
    in_a = {64{8'h03}}; in_b = {64{8'h05}};
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin in_valid = pat[i]; step(); end
    in_valid = 0;
    chk("t2 in_ready after 4th", in_ready, 1'b0);
    wait_res(10);
    chk("t2 res_data", res_data, 3840);
    handshake();

    // negative extreme result, then hold it under back-pressure
    start_job(8'd1);
    in_valid = 1; in_a = {64{8'h7f}}; in_b = {64{8'h80}};
    step();
    in_valid = 0;
    wait_res(10);
    chk("t3 res_data negative", res_data, 32'hFFF02000);
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      start = i[0]; len = 8'd3; in_valid = 1; step();
      chk("t3 res_data held", res_data, held);
      chk("t3 in_ready held", in_ready, 1'b0);
    end
    start = 0; in_valid = 0;
    handshake();

    // abort with chunks in flight, then a clean job
    start_job(8'd5);
    in_valid = 1; in_a = {64{8'h11}}; in_b = {64{8'h22}};
    step(); step();
    in_valid = 0; abort = 1; step(); abort = 0;
    chk("t4 busy after abort", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin step(); chk("t4 no result", res_valid, 1'b0); end
    start_job(8'd1);
    in_valid = 1; in_a = {64{8'h01}}; in_b = {64{8'h01}};
    step(); in_valid = 0;
    wait_res(10);
    chk("t4 res_data clean", res_data, 64);
    handshake();

    // zero-length job, and start with abort from idle
    start_job(8'd0);
    chk("t5 res_valid len0", res_valid, 1'b1);
    chk("t5 res_data len0", res_data, 0);
    handshake();
    start = 1; abort = 1; len = 8'd3; step(); start = 0; abort = 0;
    chk("t5 start+abort idle", busy, 1'b0);

    // asynchronous reset during drain
    start_job(8'd2);
    in_valid = 1; in_a = {64{8'h05}}; in_b = {64{8'h05}};
    step(); step();
    in_valid = 0;
    step();
    chk("t6 draining", busy, 1'b1);
    #1 rst_n = 1;
    #1;
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst in_ready", in_ready, 1'b0);
    chk("t6 rst res_valid", res_valid, 1'b0);
    chk("t6 rst res_data", res_data, 0);
    chk("t6 rst core_a", core_a, 0);
    step(); step();
    rst_n = 0;
    step();
    start_job(8'd2);
    in_valid = 1; in_a = {64{8'h02}}; in_b = {64{8'h02}};
    step(); step();
    in_valid = 0;
    wait_res(10);
    chk("t6 res_data after reset", res_data, 512);
    handshake();

    // randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 4) == 0;
      len       = LEN_W'($urandom % 9);
      in_valid  = ($urandom % 3) != 0;
      in_a      = rnd512();
      in_b      = rnd512();
      res_ready = $urandom % 2;
      abort     = ($urandom % 64) == 0;
      step();
    end
    start = 0; in_valid = 0; res_ready = 0; abort = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dot_job_sequencer.md
Name: dot_job_sequencer

Overview:
Sequences multi-chunk dot-product jobs through the 64-lane 8-bit dot-product core (512-bit A/B operands, signed 24-bit registered result).
- Accepts a job length in 512-bit chunks and streams operand chunk pairs into the core under a valid/ready handshake.
- Tracks in-flight chunks through the core's fixed latency and accumulates the per-chunk results into a 32-bit signed total.
- Presents the total on a valid/ready result port.
- Sits between the operand fetch logic and the core.

Parameters:
CORE_LAT, 2, cycles from a change on core_a/core_b to the corresponding core_out value (core multiplier stage plus output register)
LEN_W, 8, width of the job length field (max 255 chunks)
ACC_W, 32, accumulator/result width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
start  input  1  job start pulse, sampled in IDLE only
len  input  LEN_W  job length in chunks, sampled with start
abort  input  1  cancel current job
busy  output  1  high when state != IDLE
in_valid  input  1  operand chunk valid
in_ready  output  1  sequencer accepts chunk
in_a  input  512  operand A chunk (64 x 8-bit lanes)
in_b  input  512  operand B chunk
core_a  output  512  registered operand A to core
core_b  output  512  registered operand B to core
core_out  input  24  signed per-chunk dot product from core
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  ACC_W  signed job total

Behaviour:
- Reset, asynchronous: state IDLE; core_a, core_b, res_data, acc, chunk counter and tag pipe are 0; busy, in_ready and res_valid are 0. The core shares rst_n, so core_out is also 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with len != 0 latches len, clears acc and counter, then goes to RUN.
  - start with len == 0 clears acc, then goes to DONE, so res_valid is 1 on the next cycle with res_data = 0.
- RUN:
  - in_ready = 1, combinationally from state.
  - On an edge with in_valid & in_ready, core_a/core_b take in_a/in_b, a 1 is shifted into the tag pipe, and the counter increments.
  - On any edge without acceptance, core_a/core_b take 0 and a 0 is shifted into the tag pipe.
  - Gaps in in_valid are allowed and add nothing.
  - When the accepted count reaches len, the state goes to DRAIN on that same edge.
- Tag pipe: depth CORE_LAT+1. When the output stage holds 1, acc <= acc + sign_extend(core_out) on that edge. For a chunk accepted at edge E0, the accumulate happens at edge E0+CORE_LAT+1.
- DRAIN:
  - in_ready = 0; core_a/core_b are 0.
  - Leaves for DONE on the edge that performs the final pending accumulate (tag pipe becomes empty).
  - res_valid is therefore high CORE_LAT+1 cycles after the accepting edge of the last chunk.
- DONE:
  - res_valid = 1 and res_data = acc, held stable until res_valid & res_ready.
  - On that handshake edge: state goes to IDLE and res_valid goes to 0. res_data keeps its last value.
  - start is ignored in RUN, DRAIN and DONE.
- abort:
  - Effective in any state and takes priority over start, chunk acceptance and result handshake in the same cycle.
  - Next edge: state IDLE, tag pipe cleared (in-flight core results are discarded), acc and counter 0, res_valid 0, core_a/core_b 0.
  - abort in IDLE is a no-op.
- Arithmetic:
  - core_out is treated as signed 24-bit and sign-extended to ACC_W.
  - The accumulator wraps two's-complement; with 255 chunks of at most |2^20| it cannot overflow at ACC_W=32.
- busy is 1 in RUN, DRAIN and DONE.

Test Plan:
- len=1, all lanes A=0x01 and B=0x02, accepted at edge E0 -> res_valid rises at E0+3 (CORE_LAT=2), res_data=128; busy falls on the res_ready handshake edge.
- len=4, every lane A=0x03 and B=0x05, in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 chunks accepted, res_data=3840, in_ready=0 after the 4th acceptance.
- Complete a job, then hold res_ready=0 for 10 cycles while pulsing start and driving in_valid -> res_data stays constant, in_ready=0, no new job starts; res_ready=1 returns to IDLE in one cycle.
- len=5, abort asserted after 2 chunks accepted (chunks still in flight) -> next cycle busy=0, res_valid never asserts; following job len=1 with A=B=0x01 gives res_data=64, uncontaminated.
- start with len=0 -> res_valid=1 the next cycle with res_data=0; start and abort asserted in the same cycle from IDLE -> stays IDLE.
- Reset asserted mid-DRAIN -> all outputs 0 immediately, state IDLE; after release a len=2 job with A=0x02 and B=0x02 gives 512.
